// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline types for the hazard sequencer and the stage modules:
// register-address width, sequencer state encoding and the bundled
// stall/flush control word.
package pipe_hazard_ctrl_pkg;

  // RV32 register file address width (x0..x31)
  localparam int RegAddrWidth = 5;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_WAIT  = 2'd1,
    DRAIN     = 2'd2,
    SYS_ISSUE = 2'd3
  } hazard_state_t;

  // One control word per cycle so a stage can take a single input
  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic flush_id;
    logic flush_ex;
  } pipe_ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW comparator between the EX destination and the ID sources.
// Only loads (no forwarding path yet) and branch operands (consumed in ID,
// before the EX forward is available) need a stall.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [RegAddrWidth-1:0] id_rs1,
  input  logic [RegAddrWidth-1:0] id_rs2,
  input  logic [RegAddrWidth-1:0] ex_rd,
  input  logic                    ex_wb_en,
  input  logic                    ex_is_load,
  input  logic                    id_is_branch,
  output logic                    loadUse,
  output logic                    brHaz
);

  logic haz;

  // x0 is never a real dependency; unused sources are encoded as x0
  assign haz     = ex_wb_en && (ex_rd != '0) &&
                   ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign loadUse = haz && ex_is_load;
  assign brHaz   = haz && id_is_branch;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline. Hazard stalls
// and branch flushes are evaluated combinationally every cycle; memory waits
// and the pre-SysCall drain are tracked by a small FSM with two counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DrainDepth = 3,
  parameter int MemTimeout = 255
) (
  input  logic                    iClk,
  input  logic                    nRst,
  input  logic [RegAddrWidth-1:0] iIdRs1Addr,
  input  logic [RegAddrWidth-1:0] iIdRs2Addr,
  input  logic                    iIdIsBranch,
  input  logic                    iIdIsSys,
  input  logic                    iIdBrTrue,
  input  logic [RegAddrWidth-1:0] iExRdAddr,
  input  logic                    iExWbEn,
  input  logic                    iExIsLoad,
  input  logic                    iMemBusy,
  output logic                    oStallIF,
  output logic                    oStallID,
  output logic                    oStallEX,
  output logic                    oStallMEM,
  output logic                    oFlushID,
  output logic                    oFlushEX,
  output logic                    oSysGo,
  output logic                    oMemErr
);

  localparam int TmoW = $clog2(MemTimeout + 1);
  localparam int DrnW = (DrainDepth < 2) ? 1 : $clog2(DrainDepth + 1);
  localparam logic [TmoW-1:0] TmoMax  = TmoW'(MemTimeout);
  localparam logic [DrnW-1:0] DrnInit = DrnW'(DrainDepth);

  hazard_state_t   state_q, state_d;
  logic [TmoW-1:0] tmo_q, tmo_d, tmo_inc;
  logic [DrnW-1:0] drn_q, drn_d;
  logic            err_q, err_d;
  logic            load_use, br_haz, haz;
  logic            run_eval, sys_go;
  pipe_ctrl_t      ctrl;

  hazard_detect u_hazard_detect (
    .id_rs1       (iIdRs1Addr),
    .id_rs2       (iIdRs2Addr),
    .ex_rd        (iExRdAddr),
    .ex_wb_en     (iExWbEn),
    .ex_is_load   (iExIsLoad),
    .id_is_branch (iIdIsBranch),
    .loadUse      (load_use),
    .brHaz        (br_haz)
  );

  assign haz     = load_use || br_haz;
  // busy-cycle counter saturates at the timeout value
  assign tmo_inc = (tmo_q == TmoMax) ? tmo_q : tmo_q + TmoW'(1);

  // Next-state, counters and stall/flush word; defaults first
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    drn_d    = drn_q;
    err_d    = err_q;
    ctrl     = '0;
    sys_go   = 1'b0;
    run_eval = 1'b0;

    unique case (state_q)
      RUN: run_eval = 1'b1;

      MEM_WAIT: begin
        if (iMemBusy) begin
          ctrl.stall_if  = 1'b1;
          ctrl.stall_id  = 1'b1;
          ctrl.stall_ex  = 1'b1;
          ctrl.stall_mem = 1'b1;
          tmo_d          = tmo_inc;
          if (tmo_inc == TmoMax) err_d = 1'b1;
          // timeout reached: abandon the access and let the pipe move
          if (tmo_q == TmoMax) begin
            state_d = RUN;
            tmo_d   = '0;
          end
        end else begin
          // memory answered this cycle: MEM completes, pipe behaves as RUN
          tmo_d    = '0;
          state_d  = RUN;
          run_eval = 1'b1;
        end
      end

      DRAIN: begin
        ctrl.stall_if = 1'b1;
        ctrl.stall_id = 1'b1;
        ctrl.flush_ex = 1'b1;
        if (iMemBusy) begin
          ctrl.stall_ex  = 1'b1;
          ctrl.stall_mem = 1'b1;
        end else if (drn_q <= DrnW'(1)) begin
          drn_d   = '0;
          state_d = SYS_ISSUE;
        end else begin
          drn_d = drn_q - DrnW'(1);
        end
      end

      SYS_ISSUE: begin
        sys_go  = 1'b1;
        state_d = RUN;
      end

      default: state_d = RUN;
    endcase

    // Priority: memory wait > drain start > hazard stall > branch flush
    if (run_eval) begin
      if (iMemBusy) begin
        ctrl.stall_if  = 1'b1;
        ctrl.stall_id  = 1'b1;
        ctrl.stall_ex  = 1'b1;
        ctrl.stall_mem = 1'b1;
        tmo_d          = tmo_inc;
        if (tmo_inc == TmoMax) err_d = 1'b1;
        state_d        = MEM_WAIT;
      end else if (iIdIsSys && !haz) begin
        ctrl.stall_if = 1'b1;
        ctrl.stall_id = 1'b1;
        ctrl.flush_ex = 1'b1;
        drn_d         = DrnInit;
        state_d       = DRAIN;
      end else if (haz) begin
        // stalled branch re-resolves next cycle, so no redirect now
        ctrl.stall_if = 1'b1;
        ctrl.stall_id = 1'b1;
        ctrl.flush_ex = 1'b1;
      end else if (iIdBrTrue) begin
        ctrl.flush_id = 1'b1;
      end
    end
  end

  // State, counters and sticky error; reset aborts any drain or wait
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q <= RUN;
      tmo_q   <= '0;
      drn_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      drn_q   <= drn_d;
      err_q   <= err_d;
    end
  end

  // Controls are forced low while reset is held
  assign oStallIF  = nRst && ctrl.stall_if;
  assign oStallID  = nRst && ctrl.stall_id;
  assign oStallEX  = nRst && ctrl.stall_ex;
  assign oStallMEM = nRst && ctrl.stall_mem;
  assign oFlushID  = nRst && ctrl.flush_id;
  assign oFlushEX  = nRst && ctrl.flush_ex;
  assign oSysGo    = nRst && sys_go;
  assign oMemErr   = err_q;

endmodule
